// File: rtl/noc_pkg.sv
// noc_pkg: shared types and constants for the NoC filter-delivery path.
//   state_t   : receiver pass state (IDLE, LOAD, DONE, FULL)
//   NOC_DEPTH : default filter scratchpad depth in words
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_FULL = 2'd3
  } state_t;

  localparam int NOC_DEPTH = 224;

endpackage

// File: rtl/filter_pos_counter.sv
// filter_pos_counter: nested p (fastest) / q / S position counters plus a
// linear word counter. All counters wrap to zero together on the final word.
// Ports:
//   clk, reset        : falling-edge clock, async active-high reset
//   clear, en         : synchronous clear (wins) and advance enable
//   p_lim/q_lim/s_lim : loop extents (each must be non-zero when enabled)
//   p_cnt/q_cnt/s_cnt : current nested position
//   word_cnt          : linear index = s_cnt*p*q + q_cnt*p + p_cnt
//   last              : current position is the final word of the pass
module filter_pos_counter #(
  parameter int P_W    = 5,
  parameter int Q_W    = 3,
  parameter int S_W    = 6,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [P_W-1:0]    p_lim,
  input  logic [Q_W-1:0]    q_lim,
  input  logic [S_W-1:0]    s_lim,
  output logic [P_W-1:0]    p_cnt,
  output logic [Q_W-1:0]    q_cnt,
  output logic [S_W-1:0]    s_cnt,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              last
);

  logic [P_W-1:0]    p_cnt_r;
  logic [Q_W-1:0]    q_cnt_r;
  logic [S_W-1:0]    s_cnt_r;
  logic [ADDR_W-1:0] word_cnt_r;
  logic              p_wrap_s;
  logic              q_wrap_s;
  logic              s_wrap_s;

  // Wrap conditions for each loop level
  always_comb begin
    p_wrap_s = (p_cnt_r == (p_lim - P_W'(1)));
    q_wrap_s = (q_cnt_r == (q_lim - Q_W'(1)));
    s_wrap_s = (s_cnt_r == (s_lim - S_W'(1)));
  end

  // Nested counter state; inner loop carries into the next on wrap
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      p_cnt_r    <= '0;
      q_cnt_r    <= '0;
      s_cnt_r    <= '0;
      word_cnt_r <= '0;
    end else if (clear) begin
      p_cnt_r    <= '0;
      q_cnt_r    <= '0;
      s_cnt_r    <= '0;
      word_cnt_r <= '0;
    end else if (en) begin
      if (p_wrap_s) begin
        p_cnt_r <= '0;
        if (q_wrap_s) begin
          q_cnt_r <= '0;
          s_cnt_r <= s_wrap_s ? '0 : (s_cnt_r + S_W'(1));
        end else begin
          q_cnt_r <= q_cnt_r + Q_W'(1);
        end
      end else begin
        p_cnt_r <= p_cnt_r + P_W'(1);
      end
      word_cnt_r <= last ? '0 : (word_cnt_r + ADDR_W'(1));
    end
  end

  assign p_cnt    = p_cnt_r;
  assign q_cnt    = q_cnt_r;
  assign s_cnt    = s_cnt_r;
  assign word_cnt = word_cnt_r;
  assign last     = p_wrap_s && q_wrap_s && s_wrap_s;

endmodule

// File: rtl/filter_spad_writer.sv
// filter_spad_writer: PE-side receiver of the filter multicast stream.
// Keeps words whose row tag equals row_id and writes them linearly into the
// filter scratchpad (p fastest, then q, then S). After a full pass it pulses
// done and holds the contents, back-pressuring matching words until
// pe_release. Non-matching words are always drained so the multicast
// stream is never stalled by a PE that does not want them.
// Ports:
//   clk, reset             : falling-edge clock, async active-high reset
//   start, S, p, q, row_id : pass configuration (start sampled in IDLE)
//   in_valid/in_row/in_col/in_data, in_ready : tagged input stream
//   pe_release             : PE done with spad contents, permits refill
//   spad_we/spad_waddr/spad_wdata : registered scratchpad write port
//   busy, done             : LOAD indicator, end-of-pass pulse
//   col_error, cfg_error   : sticky error flags (cleared by reset only)
module filter_spad_writer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int R_WIDTH    = 4,
  parameter int S_WIDTH    = 6,
  parameter int p_WIDTH    = 5,
  parameter int q_WIDTH    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = NOC_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [R_WIDTH-1:0]    row_id,
  input  logic [S_WIDTH-1:0]    S,
  input  logic [p_WIDTH-1:0]    p,
  input  logic [q_WIDTH-1:0]    q,
  input  logic                  in_valid,
  input  logic [R_WIDTH-1:0]    in_row,
  input  logic [S_WIDTH-1:0]    in_col,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  pe_release,
  output logic                  spad_we,
  output logic [ADDR_WIDTH-1:0] spad_waddr,
  output logic [DATA_WIDTH-1:0] spad_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  col_error,
  output logic                  cfg_error
);

  localparam int TOT_W = p_WIDTH + q_WIDTH + S_WIDTH;

  state_t                  state_crnt_r;
  state_t                  state_next_s;
  logic [S_WIDTH-1:0]      s_cfg_r;
  logic [p_WIDTH-1:0]      p_cfg_r;
  logic [q_WIDTH-1:0]      q_cfg_r;
  logic [TOT_W-1:0]        total_s;
  logic                    cfg_ok_s;
  logic                    start_ok_s;
  logic                    release_s;
  logic                    load_acc_s;
  logic [S_WIDTH-1:0]      s_cnt_s;
  logic [ADDR_WIDTH-1:0]   word_cnt_s;
  logic                    last_s;
  logic                    spad_we_r;
  logic [ADDR_WIDTH-1:0]   spad_waddr_r;
  logic [DATA_WIDTH-1:0]   spad_wdata_r;
  logic                    done_r;
  logic                    col_error_r;
  logic                    cfg_error_r;

  // Pass size check and control strobes
  always_comb begin
    total_s    = TOT_W'(p) * TOT_W'(q) * TOT_W'(S);
    cfg_ok_s   = (total_s != TOT_W'(0)) && (total_s <= TOT_W'(DEPTH));
    start_ok_s = (state_crnt_r == ST_IDLE) && start && cfg_ok_s;
    release_s  = (state_crnt_r == ST_FULL) && pe_release;
    // in LOAD every word is accepted, so a matching valid word is a write
    load_acc_s = (state_crnt_r == ST_LOAD) && in_valid && (in_row == row_id);
  end

  filter_pos_counter #(
    .P_W    (p_WIDTH),
    .Q_W    (q_WIDTH),
    .S_W    (S_WIDTH),
    .ADDR_W (ADDR_WIDTH)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok_s || release_s),
    .en       (load_acc_s),
    .p_lim    (p_cfg_r),
    .q_lim    (q_cfg_r),
    .s_lim    (s_cfg_r),
    .p_cnt    (),
    .q_cnt    (),
    .s_cnt    (s_cnt_s),
    .word_cnt (word_cnt_s),
    .last     (last_s)
  );

  // State register
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_crnt_r <= ST_IDLE;
    end else begin
      state_crnt_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_crnt_r;
    case (state_crnt_r)
      ST_IDLE: begin
        if (start_ok_s) state_next_s = ST_LOAD;
        else            state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_acc_s && last_s) state_next_s = ST_DONE;
        else                      state_next_s = ST_LOAD;
      end
      ST_DONE: state_next_s = ST_FULL;
      ST_FULL: begin
        if (release_s) state_next_s = ST_LOAD;
        else           state_next_s = ST_FULL;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State-decoded outputs; matching words stall while the spad is full
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_crnt_r)
      ST_IDLE: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE, ST_FULL: begin
        in_ready = (in_row != row_id);
        busy     = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Configuration latched on every start seen in IDLE
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      s_cfg_r <= '0;
      p_cfg_r <= '0;
      q_cfg_r <= '0;
    end else if ((state_crnt_r == ST_IDLE) && start) begin
      s_cfg_r <= S;
      p_cfg_r <= p;
      q_cfg_r <= q;
    end
  end

  // Registered write port, done pulse and sticky error flags
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      spad_we_r    <= 1'b0;
      spad_waddr_r <= '0;
      spad_wdata_r <= '0;
      done_r       <= 1'b0;
      col_error_r  <= 1'b0;
      cfg_error_r  <= 1'b0;
    end else begin
      spad_we_r <= load_acc_s;
      // done lands in the DONE cycle together with the final write
      done_r    <= load_acc_s && last_s;
      if (load_acc_s) begin
        spad_waddr_r <= word_cnt_s;
        spad_wdata_r <= in_data;
        // an out-of-sequence column is flagged but still stored
        if (in_col != s_cnt_s) col_error_r <= 1'b1;
      end
      if ((state_crnt_r == ST_IDLE) && start && !cfg_ok_s) cfg_error_r <= 1'b1;
    end
  end

  assign spad_we    = spad_we_r;
  assign spad_waddr = spad_waddr_r;
  assign spad_wdata = spad_wdata_r;
  assign done       = done_r;
  assign col_error  = col_error_r;
  assign cfg_error  = cfg_error_r;

endmodule

// File: tb/tb_filter_spad_writer.sv
// Self-checking bench for filter_spad_writer. A pass-level model (word index,
// column = index / (p*q), pass size p*q*S) predicts every output each cycle;
// directed scenarios add literal expectations that pin the model.
module tb_filter_spad_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  row_id = 4'd1;
  logic [5:0]  S = 6'd0;
  logic [4:0]  p = 5'd0;
  logic [2:0]  q = 3'd0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_row = 4'd0;
  logic [5:0]  in_col = 6'd0;
  logic [15:0] in_data = 16'd0;
  logic        pe_release = 1'b0;
  logic        in_ready, spad_we, busy, done, col_error, cfg_error;
  logic [7:0]  spad_waddr;
  logic [15:0] spad_wdata;

  always #5 clk = ~clk;

  filter_spad_writer dut (
    .clk(clk), .reset(reset), .start(start), .row_id(row_id),
    .S(S), .p(p), .q(q),
    .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
    .in_ready(in_ready), .pe_release(pe_release),
    .spad_we(spad_we), .spad_waddr(spad_waddr), .spad_wdata(spad_wdata),
    .busy(busy), .done(done), .col_error(col_error), .cfg_error(cfg_error)
  );

  // ---------------- pass-level model ----------------
  // phase: 0 idle, 1 loading, 2 pass just completed, 3 holding
  int          m_phase = 0, m_idx = 0, m_total = 0, m_pq = 0;
  logic        exp_we = 1'b0, exp_done = 1'b0, exp_col = 1'b0, exp_cfg = 1'b0;
  logic [7:0]  exp_addr = 8'd0;
  logic [15:0] exp_data = 16'd0;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_idx <= 0;
      exp_we <= 1'b0; exp_done <= 1'b0; exp_col <= 1'b0; exp_cfg <= 1'b0;
      exp_addr <= 8'd0; exp_data <= 16'd0;
    end else begin
      exp_we   <= 1'b0;
      exp_done <= 1'b0;
      case (m_phase)
        0: if (start) begin
          m_pq    <= int'(p) * int'(q);
          m_total <= int'(p) * int'(q) * int'(S);
          if (int'(p) * int'(q) * int'(S) == 0 || int'(p) * int'(q) * int'(S) > 224)
            exp_cfg <= 1'b1;
          else begin
            m_phase <= 1; m_idx <= 0;
          end
        end
        1: if (in_valid && in_row == row_id) begin
          exp_we   <= 1'b1;
          exp_addr <= 8'(m_idx);
          exp_data <= in_data;
          if (int'(in_col) != m_idx / m_pq) exp_col <= 1'b1;
          if (m_idx + 1 == m_total) begin
            m_phase <= 2; m_idx <= 0; exp_done <= 1'b1;
          end else begin
            m_idx <= m_idx + 1;
          end
        end
        2: m_phase <= 3;
        3: if (pe_release) begin m_phase <= 1; m_idx <= 0; end
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  int    n_checks = 0, n_errors = 0;
  string lit_name_q[$];
  int    lit_act_q[$];
  int    lit_exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    while (lit_name_q.size() > 0)
      check(lit_name_q.pop_front(), lit_act_q.pop_front(), lit_exp_q.pop_front());
    check("in_ready", int'(in_ready),
          int'((m_phase == 1) || ((m_phase == 2 || m_phase == 3) && in_row != row_id)));
    check("busy", int'(busy), int'(m_phase == 1));
    check("spad_we", int'(spad_we), int'(exp_we));
    check("spad_waddr", int'(spad_waddr), int'(exp_addr));
    check("spad_wdata", int'(spad_wdata), int'(exp_data));
    check("done", int'(done), int'(exp_done));
    check("col_error", int'(col_error), int'(exp_col));
    check("cfg_error", int'(cfg_error), int'(exp_cfg));
  end

  // ---------------- directed stimulus ----------------
  int          wr_cnt = 0, done_cnt = 0, done_addr = -1;
  int          last_waddr = -1, last_wdata = -1;
  logic        obs_ready = 1'b0;

  task automatic lit(input string name, input int act, input int exp);
    lit_name_q.push_back(name);
    lit_act_q.push_back(act);
    lit_exp_q.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    obs_ready = in_ready;
    if (spad_we) begin
      wr_cnt++;
      last_waddr = int'(spad_waddr);
      last_wdata = int'(spad_wdata);
    end
    if (done) begin
      done_cnt++;
      done_addr = int'(spad_waddr);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int r, input int c, input int d);
    in_valid = 1'b1; in_row = 4'(r); in_col = 6'(c); in_data = 16'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic do_start(input int pp, input int qq, input int ss);
    p = 5'(pp); q = 3'(qq); S = 6'(ss);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    lit("reset_busy", int'(busy), 0);
    lit("reset_waddr", int'(spad_waddr), 0);

    // Pass 1: 12 words, foreign row 2 words interleaved
    do_start(2, 2, 3);
    wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 1) begin
        send(2, 0, 16'hBEEF);
        lit("foreign_ready", int'(obs_ready), 1);
      end
      send(1, i / 4, i);
    end
    tick(); tick();
    lit("pass1_writes", wr_cnt, 12);
    lit("pass1_done_cnt", done_cnt, 1);
    lit("pass1_done_addr", done_addr, 11);
    lit("pass1_last_data", last_wdata, 11);
    lit("pass1_col_error", int'(col_error), 0);

    // FULL blocks matching rows until release; release cycle does not accept
    in_valid = 1'b1; in_row = 4'd1; in_col = 6'd0; in_data = 16'h0100;
    tick();
    lit("full_block", int'(obs_ready), 0);
    pe_release = 1'b1;
    tick();
    lit("release_cycle_ready", int'(obs_ready), 0);
    pe_release = 1'b0;
    wr_cnt = 0;
    tick();
    lit("post_release_ready", int'(obs_ready), 1);
    in_valid = 1'b0;
    tick();
    lit("refill_writes", wr_cnt, 1);
    lit("refill_addr", last_waddr, 0);
    lit("refill_data", last_wdata, 256);

    // Wrong column at index 1 (S_cnt=0): flagged, still written, sticky
    send(1, 2, 16'h0101);
    tick();
    lit("col_err_set", int'(col_error), 1);
    lit("col_err_addr", last_waddr, 1);
    lit("col_err_data", last_wdata, 257);
    done_cnt = 0;
    for (int i = 2; i < 12; i++) send(1, i / 4, 16'h0100 + i);
    tick(); tick();
    lit("col_err_sticky", int'(col_error), 1);
    lit("pass2_done_cnt", done_cnt, 1);
    lit("pass2_done_addr", done_addr, 11);

    // Bad configurations
    do_reset();
    do_start(0, 2, 3);
    tick();
    lit("cfg_p0", int'(cfg_error), 1);
    lit("cfg_p0_busy", int'(busy), 0);
    send(1, 0, 16'h0033);
    lit("cfg_p0_ready", int'(obs_ready), 0);
    do_reset();
    do_start(31, 7, 2);
    tick();
    lit("cfg_434", int'(cfg_error), 1);
    lit("cfg_434_busy", int'(busy), 0);
    do_reset();
    do_start(28, 4, 2);
    tick();
    lit("cfg_224_ok", int'(cfg_error), 0);
    lit("cfg_224_busy", int'(busy), 1);

    // Reset mid-pass after 5 writes, then restart from address 0
    do_reset();
    do_start(2, 2, 3);
    for (int i = 0; i < 5; i++) send(1, 0, 16'h0200 + i);
    reset = 1'b1;
    wr_cnt = 0;
    tick();
    lit("mid_reset_no_write", wr_cnt, 0);
    lit("mid_reset_busy", int'(busy), 0);
    reset = 1'b0;
    tick();
    do_start(2, 2, 3);
    send(1, 0, 16'h0300);
    tick();
    lit("restart_addr", last_waddr, 0);
    lit("restart_data", last_wdata, 768);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
